// File: rtl/mem_ctrl_if.sv
// Bus bundle between the pipeline/RAM environment and the byte-serial memory controller.
interface mem_ctrl_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_done;
  logic        ma_re;
  logic        ma_we;
  logic [2:0]  ma_width;
  logic [31:0] ma_addr;
  logic [31:0] ma_wdata;
  logic [31:0] ma_rdata;
  logic        ma_done;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        stall_req;

  modport master (
    output if_req, if_addr, ma_re, ma_we, ma_width, ma_addr, ma_wdata, mem_din,
    input  if_data, if_done, ma_rdata, ma_done, mem_a, mem_dout, mem_wr, stall_req
  );

  modport slave (
    input  if_req, if_addr, ma_re, ma_we, ma_width, ma_addr, ma_wdata, mem_din,
    output if_data, if_done, ma_rdata, ma_done, mem_a, mem_dout, mem_wr, stall_req
  );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating instruction fetch and data load/store
// onto a single 8-bit RAM port with one-cycle read latency.
//
// state | meaning
// IDLE  | waiting for a request; data access wins over fetch
// READ  | N address cycles plus one trailing capture cycle
// WRITE | one byte written per cycle, N cycles
// DONE  | one-cycle completion pulse on the owning port
module mem_ctrl (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  width_q;
  logic [2:0]  nbytes;
  logic [2:0]  rd_off;
  logic [1:0]  byte_idx;
  logic [31:0] addr_q, wdata_q, buf_q;
  logic [31:0] rd_word, rd_ext;
  logic [31:0] if_data_q, ma_rdata_q;
  logic        owner_q;
  logic        accept, accept_data;
  logic        byte_rd, last_rd;
  logic        ma_done_w;

  assign nbytes   = (width_q[1:0] == 2'b00) ? 3'd1 :
                    (width_q[1:0] == 2'b01) ? 3'd2 : 3'd4;
  assign byte_rd  = (state_q == READ) && (cnt_q != 3'd0);
  assign last_rd  = (state_q == READ) && (cnt_q == nbytes);
  assign byte_idx = 2'(cnt_q - 3'd1);

  // Merge the byte arriving this cycle into the partially assembled word.
  always_comb begin
    rd_word = buf_q;
    if (byte_rd) rd_word[{byte_idx, 3'b000} +: 8] = bus.mem_din;
  end

  // Load result extension by funct3; fetches are latched with 010 so they pass unchanged.
  always_comb begin
    rd_ext = rd_word;
    case (width_q)
      3'b000:  rd_ext = {{24{rd_word[7]}}, rd_word[7:0]};
      3'b001:  rd_ext = {{16{rd_word[15]}}, rd_word[15:0]};
      3'b100:  rd_ext = {24'd0, rd_word[7:0]};
      3'b101:  rd_ext = {16'd0, rd_word[15:0]};
      default: rd_ext = rd_word;
    endcase
  end

  // Next-state and byte counter sequencing.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    accept      = 1'b0;
    accept_data = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ma_re || bus.ma_we) begin
          accept      = 1'b1;
          accept_data = 1'b1;
          cnt_d       = 3'd0;
          state_d     = bus.ma_we ? WRITE : READ;
        end else if (bus.if_req) begin
          accept  = 1'b1;
          cnt_d   = 3'd0;
          state_d = READ;
        end
      end
      READ: begin
        if (cnt_q == nbytes) begin
          state_d = DONE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      WRITE: begin
        if (cnt_q == nbytes - 3'd1) begin
          state_d = DONE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // State, latched request and result registers; rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      width_q    <= 3'd0;
      owner_q    <= 1'b0;
      buf_q      <= 32'd0;
      if_data_q  <= 32'd0;
      ma_rdata_q <= 32'd0;
    end else if (rdy) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        owner_q <= accept_data;
        addr_q  <= accept_data ? bus.ma_addr : bus.if_addr;
        wdata_q <= bus.ma_wdata;
        width_q <= accept_data ? bus.ma_width : 3'b010;
        buf_q   <= 32'd0;
      end else if (byte_rd) begin
        buf_q <= rd_word;
      end
      if (last_rd) begin
        if (owner_q) ma_rdata_q <= rd_ext;
        else         if_data_q  <= rd_word;
      end
    end
  end

  // While frozen mid-read, re-present the address whose byte is still owed so the
  // one-cycle-latency RAM returns it again when rdy comes back.
  assign rd_off = (!rdy && cnt_q != 3'd0) ? cnt_q - 3'd1 : cnt_q;

  // RAM port drive; the write strobe is also cut by rst so a reset cycle never writes.
  always_comb begin
    bus.mem_a    = 32'd0;
    bus.mem_dout = 8'd0;
    bus.mem_wr   = 1'b0;
    case (state_q)
      READ: bus.mem_a = addr_q + {29'd0, rd_off};
      WRITE: begin
        bus.mem_a    = addr_q + {29'd0, cnt_q};
        bus.mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        bus.mem_wr   = rdy & rst;
      end
      default: ;
    endcase
  end

  assign ma_done_w     = (state_q == DONE) && owner_q;
  assign bus.ma_done   = ma_done_w;
  assign bus.if_done   = (state_q == DONE) && !owner_q;
  assign bus.if_data   = if_data_q;
  assign bus.ma_rdata  = ma_rdata_q;
  assign bus.stall_req = (bus.ma_re | bus.ma_we) & ~ma_done_w;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: a byte-array RAM model behind the DUT, a reference
// byte array updated at request issue, and a monitor that checks every completion.
module tb_mem_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  mem_ctrl_if bus();

  mem_ctrl dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] v; int c; } exp_t;
  exp_t q_if[$];
  exp_t q_ma[$];

  logic [7:0]  ram     [256];
  logic [7:0]  ref_ram [256];
  logic        fill, pl_en;
  logic [7:0]  pl_a, pl_d;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          rand_on = 0;
  logic [31:0] model_ma_last = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM with one-cycle read latency, plus bench-side fill/poke ports.
  always @(posedge clk) begin
    bus.mem_din <= ram[bus.mem_a[7:0]];
    if (fill) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i * 37 + 11);
    end else if (bus.mem_wr) begin
      ram[bus.mem_a[7:0]] <= bus.mem_dout;
    end else if (pl_en) begin
      ram[pl_a] <= pl_d;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int nb(input logic [2:0] w);
    return (w[1:0] == 2'b00) ? 1 : (w[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] w, input logic [31:0] a, input bit fetch);
    int n;
    longint v;
    logic [31:0] ai;
    n = fetch ? 4 : nb(w);
    v = 0;
    for (int i = 0; i < n; i++) begin
      ai = a + 32'(i);
      v = v + (longint'(ref_ram[ai[7:0]]) << (8 * i));
    end
    if (!fetch && !w[2] && n < 4 && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic model_store(input logic [2:0] w, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] ai;
    for (int i = 0; i < nb(w); i++) begin
      ai = a + 32'(i);
      ref_ram[ai[7:0]] = 8'(wd >> (8 * i));
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    ref_ram[a] = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // One requester: issue, optionally check the RAM bus cycle by cycle, wait for completion.
  task automatic master(input bit fetch, input bit we, input logic [2:0] w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] ev, input int lat, input bit chk_bus);
    int t, n;
    bit got;
    exp_t e;
    n = fetch ? 4 : nb(w);
    @(negedge clk); #1;
    t = cyc;
    e.v = ev;
    e.c = (lat < 0) ? -1 : t + lat;
    if (fetch) begin
      q_if.push_back(e);
      bus.if_req = 1'b1; bus.if_addr = a;
    end else begin
      q_ma.push_back(e);
      bus.ma_re = ~we; bus.ma_we = we; bus.ma_width = w; bus.ma_addr = a; bus.ma_wdata = wd;
    end
    got = 0;
    for (int k = 1; k <= 300 && !got; k++) begin
      @(negedge clk); #1;
      if (chk_bus && k <= n) begin
        chk("mem_a", bus.mem_a, a + 32'(k - 1));
        chk("mem_wr", 32'(bus.mem_wr), 32'(we && !fetch));
        if (we && !fetch) chk("mem_dout", 32'(bus.mem_dout), 32'(8'(wd >> (8 * (k - 1)))));
      end
      if (chk_bus && k == 1) begin
        bus.if_addr = $urandom; bus.ma_addr = $urandom;
        bus.ma_wdata = $urandom; bus.ma_width = 3'($urandom_range(7));
      end
      if (fetch) begin
        if (bus.if_done && rdy) got = 1;
      end else if (bus.ma_done && rdy) begin
        chk("stall_at_done", 32'(bus.stall_req), 32'd0);
        got = 1;
      end else if (!bus.ma_done) begin
        chk("stall_pending", 32'(bus.stall_req), 32'd1);
      end
      if (got && chk_bus) begin
        chk("mem_a_done", bus.mem_a, 32'd0);
        chk("mem_wr_done", 32'(bus.mem_wr), 32'd0);
      end
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL done_timeout: got no completion in 300 cycles, expected one (addr 0x%08h)", a);
    end
    if (fetch) bus.if_req = 1'b0;
    else begin bus.ma_re = 1'b0; bus.ma_we = 1'b0; end
  endtask

  task automatic freeze(input int d);
    repeat (d) @(negedge clk);
    rdy = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1 chk("mem_wr_frozen", 32'(bus.mem_wr), 32'd0);
      @(negedge clk);
    end
    rdy = 1'b1;
  endtask

  task automatic random_op();
    int kind;
    logic [2:0] ws [5];
    logic [2:0] w;
    logic [31:0] a, wd, ev;
    ws[0] = 3'b000; ws[1] = 3'b001; ws[2] = 3'b010; ws[3] = 3'b100; ws[4] = 3'b101;
    kind = $urandom_range(2);
    w = ws[$urandom_range(4)];
    a = $urandom;
    wd = $urandom;
    if (kind == 0) begin
      ev = model_load(3'b010, a, 1'b1);
      master(1'b1, 1'b0, 3'b010, a, 32'd0, ev, -1, 1'b0);
    end else if (kind == 1) begin
      ev = model_load(w, a, 1'b0);
      model_ma_last = ev;
      master(1'b0, 1'b0, w, a, 32'd0, ev, -1, 1'b0);
    end else begin
      model_store(w, a, wd);
      master(1'b0, 1'b1, w, a, wd, model_ma_last, -1, 1'b0);
    end
  endtask

  initial begin
    logic [31:0] ev_d, ev_f, wd;
    exp_t e;
    rst = 1'b0; rdy = 1'b1; fill = 1'b1; pl_en = 1'b0; pl_a = 8'd0; pl_d = 8'd0;
    bus.if_req = 1'b0; bus.if_addr = 32'd0; bus.ma_re = 1'b0; bus.ma_we = 1'b0;
    bus.ma_width = 3'd0; bus.ma_addr = 32'd0; bus.ma_wdata = 32'd0;
    for (int i = 0; i < 256; i++) ref_ram[i] = 8'(i * 37 + 11);
    fork
      forever begin
        @(negedge clk); #1;
        if (rst && rdy && bus.if_done) begin
          if (q_if.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL if_done_unexpected: got a pulse, expected none (cycle %0d)", cyc);
          end else begin
            e = q_if.pop_front();
            chk("if_data", bus.if_data, e.v);
            if (e.c >= 0) chk("if_done_cycle", 32'(cyc), 32'(e.c));
          end
        end
        if (rst && rdy && bus.ma_done) begin
          if (q_ma.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL ma_done_unexpected: got a pulse, expected none (cycle %0d)", cyc);
          end else begin
            e = q_ma.pop_front();
            chk("ma_rdata", bus.ma_rdata, e.v);
            if (e.c >= 0) chk("ma_done_cycle", 32'(cyc), 32'(e.c));
          end
        end
      end
      begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_if_done", 32'(bus.if_done), 32'd0);
        chk("rst_ma_done", 32'(bus.ma_done), 32'd0);
        chk("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
        chk("rst_mem_a", bus.mem_a, 32'd0);
        chk("rst_mem_dout", 32'(bus.mem_dout), 32'd0);
        chk("rst_if_data", bus.if_data, 32'd0);
        chk("rst_ma_rdata", bus.ma_rdata, 32'd0);
        chk("rst_stall", 32'(bus.stall_req), 32'd0);
        fill = 1'b0; rst = 1'b1;

        // Fetch 0x100 -> 0x00000513 at t+6.
        poke(8'h00, 8'h13); poke(8'h01, 8'h05); poke(8'h02, 8'h00); poke(8'h03, 8'h00);
        master(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 32'h0000_0513, 6, 1'b1);

        // Byte loads, signed and unsigned.
        poke(8'h20, 8'h80);
        model_ma_last = 32'hFFFF_FF80;
        master(1'b0, 1'b0, 3'b000, 32'h20, 32'd0, 32'hFFFF_FF80, 3, 1'b1);
        model_ma_last = 32'h0000_0080;
        master(1'b0, 1'b0, 3'b100, 32'h20, 32'd0, 32'h0000_0080, 3, 1'b1);

        // Store word; completion leaves ma_rdata at the previous load value.
        model_store(3'b010, 32'h40, 32'hDEAD_BEEF);
        master(1'b0, 1'b1, 3'b010, 32'h40, 32'hDEAD_BEEF, model_ma_last, 5, 1'b1);
        chk("ram40", 32'(ram[8'h40]), 32'h0000_00EF);
        chk("ram41", 32'(ram[8'h41]), 32'h0000_00BE);
        chk("ram42", 32'(ram[8'h42]), 32'h0000_00AD);
        chk("ram43", 32'(ram[8'h43]), 32'h0000_00DE);

        // Halfword loads and a store wrapping past 0xFFFFFFFF.
        poke(8'h31, 8'hA5); poke(8'h32, 8'h9C);
        ev_d = model_load(3'b001, 32'h31, 1'b0); model_ma_last = ev_d;
        master(1'b0, 1'b0, 3'b001, 32'h31, 32'd0, ev_d, 4, 1'b1);
        ev_d = model_load(3'b101, 32'h31, 1'b0); model_ma_last = ev_d;
        master(1'b0, 1'b0, 3'b101, 32'h31, 32'd0, ev_d, 4, 1'b1);
        model_store(3'b001, 32'hFFFF_FFFF, 32'h0000_7E81);
        master(1'b0, 1'b1, 3'b001, 32'hFFFF_FFFF, 32'h0000_7E81, model_ma_last, 3, 1'b1);
        ev_d = model_load(3'b010, 32'hFFFF_FFFE, 1'b0); model_ma_last = ev_d;
        master(1'b0, 1'b0, 3'b010, 32'hFFFF_FFFE, 32'd0, ev_d, 6, 1'b1);

        // Fetch and load in the same IDLE cycle: load first, fetch right after.
        ev_d = model_load(3'b000, 32'h30, 1'b0); model_ma_last = ev_d;
        ev_f = model_load(3'b010, 32'h100, 1'b1);
        fork
          master(1'b0, 1'b0, 3'b000, 32'h30, 32'd0, ev_d, 3, 1'b0);
          master(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, ev_f, 10, 1'b0);
        join

        // Store arriving mid-fetch while the controller is frozen for three cycles.
        wd = $urandom;
        ev_f = model_load(3'b010, 32'h204, 1'b1);
        model_store(3'b010, 32'h50, wd);
        fork
          master(1'b1, 1'b0, 3'b010, 32'h204, 32'd0, ev_f, 9, 1'b0);
          begin repeat (2) @(negedge clk); master(1'b0, 1'b1, 3'b010, 32'h50, wd, model_ma_last, 13, 1'b0); end
          freeze(3);
        join
        ev_d = model_load(3'b010, 32'h50, 1'b0); model_ma_last = ev_d;
        master(1'b0, 1'b0, 3'b010, 32'h50, 32'd0, ev_d, 6, 1'b1);

        // Freeze inside a store's WRITE phase.
        wd = $urandom;
        model_store(3'b010, 32'h80, wd);
        fork
          master(1'b0, 1'b1, 3'b010, 32'h80, wd, model_ma_last, 8, 1'b0);
          freeze(3);
        join
        ev_d = model_load(3'b010, 32'h80, 1'b0); model_ma_last = ev_d;
        master(1'b0, 1'b0, 3'b010, 32'h80, 32'd0, ev_d, 6, 1'b1);

        // Reset in the third WRITE cycle of a word store: only two bytes land.
        poke(8'h60, 8'h00); poke(8'h61, 8'h00); poke(8'h62, 8'h00); poke(8'h63, 8'h00);
        @(negedge clk); #1;
        bus.ma_we = 1'b1; bus.ma_width = 3'b010; bus.ma_addr = 32'h60; bus.ma_wdata = 32'h1122_3344;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1 chk("rst_mid_mem_wr", 32'(bus.mem_wr), 32'd0);
        @(negedge clk); #1;
        chk("rst_mid_ma_done", 32'(bus.ma_done), 32'd0);
        chk("rst_mid_mem_wr2", 32'(bus.mem_wr), 32'd0);
        chk("rst_mid_mem_a", bus.mem_a, 32'd0);
        chk("rst_mid_if_data", bus.if_data, 32'd0);
        chk("rst_mid_ma_rdata", bus.ma_rdata, 32'd0);
        bus.ma_we = 1'b0;
        rst = 1'b1;
        model_ma_last = 32'd0;
        ref_ram[8'h60] = 8'h44; ref_ram[8'h61] = 8'h33;
        chk("ram60", 32'(ram[8'h60]), 32'h0000_0044);
        chk("ram61", 32'(ram[8'h61]), 32'h0000_0033);
        chk("ram62", 32'(ram[8'h62]), 32'h0000_0000);
        chk("ram63", 32'(ram[8'h63]), 32'h0000_0000);

        // Random traffic with random rdy stalls.
        rand_on = 1;
        fork
          begin
            for (int i = 0; i < 150; i++) random_op();
            rand_on = 0;
          end
          begin
            while (rand_on) begin
              @(negedge clk);
              if (rand_on) rdy = ($urandom_range(3) != 0);
            end
            rdy = 1'b1;
          end
        join

        repeat (5) @(negedge clk);
        chk("q_if_empty", 32'(q_if.size()), 32'd0);
        chk("q_ma_empty", 32'(q_ma.size()), 32'd0);
      end
    join_any
    disable fork;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have one clock and one reset: the reset is synchronous and active-low.
REQ-002 SHALL provide: clk  input  1  rising-edge clock.
REQ-003 SHALL provide: rst  input  1  synchronous reset, active-low (rst==0 resets).
REQ-004 SHALL provide: rdy  input  1  global enable; 0 freezes all state.
REQ-005 SHALL provide: if_req  input  1  fetch request, level, held until if_done.
REQ-006 SHALL provide: if_addr  input  32  fetch byte address.
REQ-007 SHALL provide: if_data  output  32  fetched instruction, valid with if_done.
REQ-008 SHALL provide: if_done  output  1  one-cycle fetch completion pulse.
REQ-009 SHALL provide: ma_re, ma_we  input  1 each  data load/store request, level, held until ma_done.
REQ-010 SHALL provide: ma_width  input  3  funct3 code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-011 SHALL provide: ma_addr, ma_wdata  input  32 each  data address and store data.
REQ-012 SHALL provide: ma_rdata  output  32  load result, valid with ma_done.
REQ-013 SHALL provide: ma_done  output  1  one-cycle data completion pulse.
REQ-014 SHALL provide: mem_a  output  32  RAM byte address.
REQ-015 SHALL provide: mem_dout  output  8  RAM write byte.
REQ-016 SHALL provide: mem_wr  output  1  RAM write strobe.
REQ-017 SHALL provide: mem_din  input  8  RAM read byte, one-cycle latency.
REQ-018 SHALL provide: stall_req  output  1  pipeline stall for pending data access.

Function
REQ-019 SHALL implement states IDLE, READ, WRITE, DONE with a 3-bit byte counter.
REQ-020 In IDLE, SHALL accept ma_re/ma_we over if_req; SHALL treat ma_re&ma_we as a store.
REQ-021 SHALL NOT abort an in-flight fetch; a data request waits for the fetch's DONE.
REQ-022 SHALL use byte count N = 1 (width[1:0]=00), 2 (01), 4 (10 or 11); fetch N=4.
REQ-023 Accept at cycle t: byte i (i=0..N-1) SHALL be driven on mem_a = addr+i in cycle t+1+i, 32-bit wrap.
REQ-024 Reads: SHALL capture mem_din in cycle t+2+i as byte i, little-endian; READ lasts N+1 cycles.
REQ-025 Writes: SHALL assert mem_wr=1 with mem_dout = wdata[8i+7:8i] in cycle t+1+i; WRITE lasts N cycles.
REQ-026 SHALL enter DONE for exactly one cycle after the last READ/WRITE cycle, pulse the owning done, then go to IDLE.
REQ-027 Load latency SHALL be N+2 cycles; store latency SHALL be N+1 cycles.
REQ-028 No request SHALL be accepted in DONE; the next acceptance is at the earliest in the following IDLE cycle.
REQ-029 ma_rdata SHALL be sign-extended for 000/001 and zero-extended for 100/101; if_data SHALL not be extended.
REQ-030 if_data/ma_rdata SHALL hold their last value until the next completion of the same port.
REQ-031 Outside WRITE, mem_wr SHALL be 0 and mem_dout SHALL be 0; in IDLE/DONE, mem_a SHALL be 0.
REQ-032 stall_req SHALL be (ma_re|ma_we)&~ma_done, combinational.
REQ-033 With rdy=0, SHALL hold state, counter and registers, and force mem_wr=0; the access SHALL resume when rdy returns.
REQ-034 Request address/data/width SHALL be latched at acceptance; later input changes SHALL be ignored.

Reset
REQ-035 With rst==0 at a clock edge, SHALL go to IDLE and clear the counter, if_data, ma_rdata, if_done, ma_done, mem_a, mem_dout and mem_wr to 0, including mid-access.
REQ-036 Reset SHALL take priority over rdy.

Verification
REQ-037 Fetch: if_req at 0x100, RAM bytes 13,05,00,00 -> if_done in cycle t+6, if_data=0x00000513, mem_a 0x100..0x103.
REQ-038 Load byte: ma_re, width 000, addr 0x20, byte 0x80 -> ma_done at t+3, ma_rdata=0xFFFFFF80; width 100 -> 0x00000080.
REQ-039 Store word: ma_we, width 010, addr 0x40, wdata 0xDEADBEEF -> mem_wr in t+1..t+4 with bytes EF,BE,AD,DE at 0x40..0x43, ma_done at t+5.
REQ-040 Contention: if_req and ma_re in the same IDLE cycle -> data served first; fetch accepted the cycle after DONE; stall_req=1 until ma_done.
REQ-041 Mid-fetch data request plus rdy=0 for 3 cycles -> fetch completes 3 cycles late with correct data, then data access runs, and mem_wr=0 during the freeze.
REQ-042 rst=0 during the third WRITE cycle of a SW -> next cycle IDLE, mem_wr=0, no ma_done; only 2 bytes were written.
